sqrt_stim_sequencer: RTL and testbench

//  Upstream stimulus stage for sqrtFixedPoint on the nano20k board.

---
 rtl/sqrt_stim_pkg.sv | 29 ++
 rtl/sqrt_stim_hold_timer.sv | 37 +++
 rtl/sqrt_stim_sequencer.sv | 141 ++++++++++++++
 tb/tb_sqrt_stim_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sqrt_stim_pkg.sv
// Shared types and constants for the sqrt stimulus sequencer.
// The LFSR tap table is only consumed when STIM_LFSR_EN is defined.
package sqrt_stim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS_8  = 16'h00B8;
  localparam logic [15:0] LFSR_TAPS_12 = 16'h0E08;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Wide enough to hold HOLD_CYCLES itself, so HOLD_CYCLES-1 always fits.
  function automatic int unsigned timer_width(input int unsigned hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return LFSR_TAPS_8;
      12:      return LFSR_TAPS_12;
      16:      return LFSR_TAPS_16;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sqrt_stim_hold_timer.sv
// Loadable down-counter that paces the sequencer's HOLD phase.
// Load wins over count; the counter parks at zero.
module sqrt_stim_hold_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/sqrt_stim_sequencer.sv
// Ramp (or, with STIM_LFSR_EN, LFSR) code generator feeding sqrtFixedPoint over valid/ready,
// holding HOLD_CYCLES after each accepted code so the result stays visible on the LEDs.
module sqrt_stim_sequencer
  import sqrt_stim_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned HOLD_CYCLES = 27000000,
  parameter int unsigned START       = 0,
  parameter int unsigned STEP        = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_single,
  input  logic              i_ready,
`ifdef STIM_LFSR_EN
  input  logic              i_mode,
`endif
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_wrap
);

  localparam int unsigned       TW      = timer_width(HOLD_CYCLES);
  localparam logic [TW-1:0]     HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [DATA_W-1:0] START_C = DATA_W'(START);
  localparam logic [DATA_W-1:0] STEP_C  = DATA_W'(STEP);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              wrap_q, wrap_d;
  logic              single_pend_q, single_pend_d;
  logic              timer_load, timer_zero;
  logic [DATA_W-1:0] next_code;
  logic              next_wrap;
  logic [DATA_W:0]   ramp_sum;

  assign ramp_sum = {1'b0, code_q} + {1'b0, STEP_C};

`ifdef STIM_LFSR_EN
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
  localparam logic [DATA_W-1:0] SEED = START_C | DATA_W'(1);

  if ((DATA_W != 8) && (DATA_W != 12) && (DATA_W != 16)) begin : g_bad_width
    $error("sqrt_stim_sequencer: LFSR mode supports DATA_W of 8, 12 or 16 only");
  end

  logic              mode_q, mode_d;
  logic [DATA_W-1:0] lfsr_next;

  assign lfsr_next = {code_q[DATA_W-2:0], ^(code_q & TAPS)};
  assign next_code = mode_q ? lfsr_next : ramp_sum[DATA_W-1:0];
  assign next_wrap = mode_q ? (lfsr_next == SEED) : ramp_sum[DATA_W];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end
`else
  assign next_code = ramp_sum[DATA_W-1:0];
  assign next_wrap = ramp_sum[DATA_W];
`endif

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    wrap_d        = 1'b0;
    single_pend_d = single_pend_q;
    timer_load    = 1'b0;
    o_valid       = 1'b0;
`ifdef STIM_LFSR_EN
    mode_d        = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Enable takes priority; a single shot only arms when enable is low.
        if (i_enable || (i_single && !single_pend_q)) begin
          state_d       = PRESENT;
          single_pend_d = !i_enable;
`ifdef STIM_LFSR_EN
          mode_d = i_mode;
          if (i_mode && !mode_q) begin
            code_d = SEED;
          end
`endif
        end
      end
      PRESENT: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d    = HOLD;
          timer_load = 1'b1;
        end
      end
      HOLD: begin
        if (timer_zero) begin
          code_d        = next_code;
          wrap_d        = next_wrap;
          single_pend_d = 1'b0;
          state_d       = i_enable ? PRESENT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the synchronous reset returns every register, including the code, to its defined value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      code_q        <= START_C;
      wrap_q        <= 1'b0;
      single_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      wrap_q        <= wrap_d;
      single_pend_q <= single_pend_d;
    end
  end

  sqrt_stim_hold_timer #(
    .WIDTH (TW)
  ) u_hold_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (timer_load),
    .i_load_val (HOLD_LD),
    .i_en       (state_q == HOLD),
    .o_zero     (timer_zero)
  );

  assign o_data = code_q;
  assign o_busy = (state_q != IDLE);
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_sqrt_stim_sequencer.sv
// Directed bench for sqrt_stim_sequencer: reset, free-run pacing, back-pressure,
// wrap at 255->0, single shot, mid-HOLD reset and the HOLD_CYCLES=1 corner.
module tb_sqrt_stim_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: HOLD_CYCLES=4, START=0
  logic       reset, enable, single, ready;
  logic       valid, busy, wrap;
  logic [7:0] data;

  // Wrap instance (START=254) and HOLD_CYCLES=1 instance share one set of inputs
  logic       w_reset, w_enable, w_single, w_ready;
  logic       w_valid, w_busy, w_wrap;
  logic [7:0] w_data;
  logic       h_valid, h_busy, h_wrap;
  logic [7:0] h_data;

  int n_vec = 0;
  int n_err = 0;

  sqrt_stim_sequencer #(.DATA_W(8), .HOLD_CYCLES(4), .START(0), .STEP(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_single(single), .i_ready(ready),
    .o_valid(valid), .o_data(data), .o_busy(busy), .o_wrap(wrap)
  );

  sqrt_stim_sequencer #(.DATA_W(8), .HOLD_CYCLES(4), .START(254), .STEP(1)) dut_wrap (
    .i_clk(clk), .i_reset(w_reset), .i_enable(w_enable), .i_single(w_single), .i_ready(w_ready),
    .o_valid(w_valid), .o_data(w_data), .o_busy(w_busy), .o_wrap(w_wrap)
  );

  sqrt_stim_sequencer #(.DATA_W(8), .HOLD_CYCLES(1), .START(0), .STEP(1)) dut_h1 (
    .i_clk(clk), .i_reset(w_reset), .i_enable(w_enable), .i_single(w_single), .i_ready(w_ready),
    .o_valid(h_valid), .o_data(h_data), .o_busy(h_busy), .o_wrap(h_wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a handshake on the main instance, returns code and cycle stamp.
  task automatic wait_accept(input string tag, output logic [7:0] code, output int at);
    logic found;
    found = 1'b0;
    code  = '0;
    at    = -1;
    for (int i = 0; i < 40; i++) begin
      if (valid && ready) begin
        code  = data;
        at    = cyc;
        found = 1'b1;
        tick();
        break;
      end
      tick();
    end
    check({tag, "_accepted"}, found, 1'b1);
  endtask

  logic [7:0] c;
  int         t0, t1, t2, t3;
  int         wrap_cnt, w_n, h_n;
  logic [7:0] wrap_data, wrap_prev, prev_w;
  logic [7:0] w_codes [4];
  logic [7:0] h_codes [4];
  int         h_at    [4];

  initial begin
    reset   = 1'b1; enable   = 1'b0; single   = 1'b0; ready   = 1'b0;
    w_reset = 1'b1; w_enable = 1'b0; w_single = 1'b0; w_ready = 1'b0;

    // 1. reset state
    repeat (3) tick();
    check("rst_valid", valid, 0);
    check("rst_data",  data,  0);
    check("rst_busy",  busy,  0);
    check("rst_wrap",  wrap,  0);
    reset = 1'b0;

    // 2. free-run, codes every HOLD_CYCLES+1 cycles
    enable = 1'b1; ready = 1'b1;
    tick();
    check("lat_valid", valid, 1);
    check("lat_data",  data,  0);
    wait_accept("a0", c, t0); check("a0_code", c, 0);
    wait_accept("a1", c, t1); check("a1_code", c, 1); check("a1_gap", t1 - t0, 5);
    wait_accept("a2", c, t2); check("a2_code", c, 2); check("a2_gap", t2 - t1, 5);

    // 3. back-pressure on code 3, enable dropped while presenting
    ready = 1'b0;
    repeat (4) tick();
    check("p3_valid", valid, 1);
    check("p3_data",  data,  3);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", valid, 1);
      check("bp_data",  data,  3);
    end
    ready = 1'b1;
    wait_accept("a3", c, t3); check("a3_code", c, 3);
    repeat (4) tick();
    check("a3_idle_busy",  busy,  0);
    check("a3_idle_valid", valid, 0);
    check("a3_idle_data",  data,  4);

    // 5. single shot, second pulse during HOLD ignored
    reset = 1'b1; tick(); reset = 1'b0;
    check("s_rst_data", data, 0);
    single = 1'b1; tick(); single = 1'b0;
    check("s_valid", valid, 1);
    check("s_data",  data,  0);
    wait_accept("s0", c, t0); check("s0_code", c, 0);
    single = 1'b1; tick(); single = 1'b0;
    check("s_hold_busy", busy, 1);
    repeat (3) tick();
    check("s_end_busy",  busy,  0);
    check("s_end_valid", valid, 0);
    check("s_end_data",  data,  1);
    repeat (6) tick();
    check("s_quiet_valid", valid, 0);
    check("s_quiet_data",  data,  1);

    // 6. reset in HOLD with timer=2
    enable = 1'b1; ready = 1'b1;
    tick();
    check("r_pre_valid", valid, 1);
    check("r_pre_data",  data,  1);
    tick();
    tick();
    check("r_hold_busy", busy, 1);
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    check("r_busy",  busy,  0);
    check("r_data",  data,  0);
    check("r_valid", valid, 0);
    check("r_wrap",  wrap,  0);
    tick();
    check("r_after_valid", valid, 0);
    check("r_after_busy",  busy,  0);

    // 4. wrap 254,255,0 and the HOLD_CYCLES=1 corner
    w_reset = 1'b0; w_enable = 1'b1; w_ready = 1'b1;
    wrap_cnt = 0; w_n = 0; h_n = 0;
    wrap_data = '1; wrap_prev = '0; prev_w = '0;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (w_wrap) begin
        wrap_cnt++;
        wrap_data = w_data;
        wrap_prev = prev_w;
      end
      if (w_valid && w_ready && (w_n < 4)) begin
        w_codes[w_n] = w_data;
        w_n++;
      end
      if (h_valid && w_ready && (h_n < 4)) begin
        h_codes[h_n] = h_data;
        h_at[h_n]    = cyc;
        h_n++;
      end
      prev_w = w_data;
      tick();
    end
    check("w_count",  w_n, 3);
    check("w_code0",  w_codes[0], 254);
    check("w_code1",  w_codes[1], 255);
    check("w_code2",  w_codes[2], 0);
    check("w_pulses", wrap_cnt, 1);
    check("w_data",   wrap_data, 0);
    check("w_prev",   wrap_prev, 255);
    check("h1_count", h_n, 4);
    for (int i = 0; i < 4; i++) begin
      check("h1_code", h_codes[i], i);
      if (i > 0) check("h1_gap", h_at[i] - h_at[i-1], 2);
    end
    check("h1_wrap", h_wrap, 0);
    check("h1_busy", h_busy, 1);
    check("w_busy",  w_busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
